// File: rtl/md_issue_ctrl.sv
// E-stage issue/hazard controller for the HI/LO multiply-divide unit: decodes the instruction,
// drives the unit's ports, shadows its busy window, stalls D/E and flags divide-by-zero/busy mismatch.
module md_issue_ctrl #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 9,
    parameter int unsigned CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [31:0] e_instr,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        flush,
    input  logic        xalu_busy,
    output logic [3:0]  xalu_op,
    output logic [31:0] xalu_a,
    output logic [31:0] xalu_b,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] xalu_wdata,
    output logic        xalu_out_sel,
    output logic        md_stall,
    output logic        div0,
    output logic        busy_err,
    output logic [31:0] stall_cnt
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MADD  = 4'd5,
        OP_MADDU = 4'd6,
        OP_MSUB  = 4'd7,
        OP_MSUBU = 4'd8
    } op_e;

    localparam logic [5:0] OPC_SPECIAL  = 6'h00;
    localparam logic [5:0] OPC_SPECIAL2 = 6'h1C;

    if (2 ** CNT_W <= DIV_LAT || 2 ** CNT_W <= MUL_LAT) begin : g_cnt_w_check
        $error("md_issue_ctrl: CNT_W too narrow for the configured latencies");
    end

    logic [5:0]       opcode;
    logic [5:0]       funct;
    op_e              dec_op;
    logic             is_mfhi;
    logic             is_mthi;
    logic             is_mflo;
    logic             is_mtlo;
    logic             is_hilo_mv;
    logic             is_div_op;
    logic             md_class;
    logic             issue;
    logic             cnt_busy;
    logic             busy_exp;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             unused_instr_bits;

    assign opcode            = e_instr[31:26];
    assign funct             = e_instr[5:0];
    assign unused_instr_bits = ^e_instr[25:6];

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        dec_op  = OP_NONE;
        is_mfhi = 1'b0;
        is_mthi = 1'b0;
        is_mflo = 1'b0;
        is_mtlo = 1'b0;
        if (opcode == OPC_SPECIAL) begin
            case (funct)
                6'h18:   dec_op  = OP_MULT;
                6'h19:   dec_op  = OP_MULTU;
                6'h1A:   dec_op  = OP_DIV;
                6'h1B:   dec_op  = OP_DIVU;
                6'h10:   is_mfhi = 1'b1;
                6'h11:   is_mthi = 1'b1;
                6'h12:   is_mflo = 1'b1;
                6'h13:   is_mtlo = 1'b1;
                default: ;
            endcase
        end else if (opcode == OPC_SPECIAL2) begin
            case (funct)
                6'h00:   dec_op = OP_MADD;
                6'h01:   dec_op = OP_MADDU;
                6'h04:   dec_op = OP_MSUB;
                6'h05:   dec_op = OP_MSUBU;
                default: ;
            endcase
        end
    end

    assign is_hilo_mv = is_mfhi | is_mthi | is_mflo | is_mtlo;
    assign is_div_op  = (dec_op == OP_DIV) || (dec_op == OP_DIVU);
    assign md_class   = e_valid & ((dec_op != OP_NONE) | is_hilo_mv);
    assign cnt_busy   = (cnt != '0);

    // Stall depends only on the shadow counter, never on xalu_busy, so no loop through the unit.
    assign md_stall = md_class & cnt_busy;
    assign issue    = md_class & ~md_stall & ~flush & reset;

    assign xalu_op      = issue ? dec_op : OP_NONE;
    assign hi_we        = issue & is_mthi;
    assign lo_we        = issue & is_mtlo;
    assign xalu_out_sel = reset & e_valid & is_hilo_mv & funct[1];
    assign xalu_a       = e_rs;
    assign xalu_b       = e_rt;
    assign xalu_wdata   = e_rs;

    always_comb begin
        cnt_nxt = cnt;
        if (issue && is_div_op) begin
            cnt_nxt = CNT_W'(DIV_LAT);
        end else if (issue && dec_op != OP_NONE) begin
            cnt_nxt = CNT_W'(MUL_LAT);
        end else if (cnt_busy) begin
            cnt_nxt = cnt - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div0 <= 1'b0;
        end else begin
            div0 <= issue & is_div_op & (e_rt == 32'd0);
        end
    end

    // The unit raises BUSY combinationally when an op is presented, so include xalu_op here.
    assign busy_exp = cnt_busy | (xalu_op != OP_NONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_err <= 1'b0;
        end else if (xalu_busy != busy_exp) begin
            busy_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (md_stall && !flush && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule
